// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: default width, FSM state
// encoding and run-mode encoding.
package counter_pkg;

  localparam int CNT_WIDTH = 4;

  // 2'b11 is deliberately left unnamed; the FSM decodes it back to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/sync_counter4.sv
// Synchronous up-counter with clear (dominant) and count enable.
module sync_counter4 #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] NUM
);

  always_ff @(posedge CLK) begin
    if (clear) begin
      NUM <= '0;
    end else if (enable) begin
      NUM <= NUM + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequences a clearable up-counter through one-shot or periodic count runs
// with start/stop/pause control and a registered terminal-count pulse.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic             MODE,
  input  logic [WIDTH-1:0] TC,
  output logic [WIDTH-1:0] NUM,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       STATE
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tc_q;
  logic             mode_q;
  logic             terminal;
  logic             cnt_clear;
  logic             cnt_en;
  logic             latch_cmd;
  logic             done_nxt;

  assign terminal = (NUM == tc_q);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run parameters are captured only when a start is accepted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tc_q   <= '0;
      mode_q <= MODE_ONESHOT;
      DONE   <= 1'b0;
    end else begin
      DONE <= done_nxt;
      if (latch_cmd) begin
        tc_q   <= TC;
        mode_q <= MODE;
      end
    end
  end

  // Next-state logic; STOP outranks every other command.
  always_comb begin
    state_nxt = ST_IDLE;
    if (!STOP) begin
      case (state)
        ST_IDLE: state_nxt = START ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (!PAUSE && terminal && (mode_q == MODE_ONESHOT)) begin
            state_nxt = ST_FIN;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_FIN:  state_nxt = START ? ST_RUN : ST_FIN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath controls. A one-shot terminal simply withholds the enable,
  // which is what keeps NUM parked at tc_q through FIN.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    latch_cmd = 1'b0;
    done_nxt  = 1'b0;
    if (STOP) begin
      cnt_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_clear = 1'b1;
          latch_cmd = START;
        end
        ST_RUN: begin
          if (!PAUSE) begin
            if (terminal) begin
              done_nxt  = 1'b1;
              cnt_clear = (mode_q == MODE_PERIODIC);
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        ST_FIN: begin
          cnt_clear = START;
          latch_cmd = START;
        end
        default: cnt_clear = 1'b1;
      endcase
    end
  end

  assign BUSY  = (state == ST_RUN);
  assign STATE = state;

  sync_counter4 #(
    .WIDTH(WIDTH)
  ) u_counter (
    .CLK   (CLK),
    .clear (RESET | cnt_clear),
    .enable(cnt_en),
    .NUM   (NUM)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: one-shot, periodic, pause, stop,
// reset and terminal-count edge cases against hand-computed values.
module tb_counter_sequencer;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic         STOP = 1'b0;
  logic         PAUSE = 1'b0;
  logic         MODE = 1'b0;
  logic [W-1:0] TC = '0;
  logic [W-1:0] NUM;
  logic         BUSY;
  logic         DONE;
  logic [1:0]   STATE;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Clock / DUT
  always #5 CLK = ~CLK;

  counter_sequencer #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .START(START),
    .STOP (STOP),
    .PAUSE(PAUSE),
    .MODE (MODE),
    .TC   (TC),
    .NUM  (NUM),
    .BUSY (BUSY),
    .DONE (DONE),
    .STATE(STATE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input int num, input int busy,
                           input int done, input int st);
    check({tag, ".num"},   32'(NUM),   32'(num));
    check({tag, ".busy"},  32'(BUSY),  32'(busy));
    check({tag, ".done"},  32'(DONE),  32'(done));
    check({tag, ".state"}, 32'(STATE), 32'(st));
  endtask

  task automatic launch(input logic [W-1:0] tc, input logic mode);
    TC    = tc;
    MODE  = mode;
    START = 1'b1;
    tick();
    START = 1'b0;
    check_all("start", 0, 1, 0, 1);
  endtask

  task automatic abort();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    check_all("stop", 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held with START high
    RESET = 1'b1;
    START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("rst", 0, 0, 0, 0);
    end
    RESET = 1'b0;
    START = 1'b0;
    tick();
    check_all("post_rst", 0, 0, 0, 0);

    // One-shot TC=5
    launch(4'd5, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_all("os5", k, 1, 0, 1);
    end
    tick();
    check_all("os5_done", 5, 0, 1, 2);
    tick();
    check_all("os5_fin", 5, 0, 0, 2);
    tick();
    check_all("os5_hold", 5, 0, 0, 2);
    launch(4'd5, 1'b0);
    tick();
    check("os5_restart.num", 32'(NUM), 1);
    abort();

    // Periodic TC=3; TC change and START during run are ignored
    launch(4'd3, 1'b1);
    TC = 4'd9;
    for (int k = 1; k <= 12; k++) exp_q.push_back(W'(k % 4));
    for (int k = 1; k <= 12; k++) begin
      START = (k == 6);
      tick();
      check("per3.num", 32'(NUM), 32'(exp_q.pop_front()));
      check("per3.done", 32'(DONE), 32'(k % 4 == 0));
      check("per3.state", 32'(STATE), 1);
    end
    START = 1'b0;
    abort();

    // One-shot TC=7 with 3-cycle pause at NUM=4
    launch(4'd7, 1'b0);
    for (int k = 1; k <= 4; k++) tick();
    check("pz.num4", 32'(NUM), 4);
    PAUSE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("pz_hold", 4, 1, 0, 1);
    end
    PAUSE = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      tick();
      check_all("pz_run", k, 1, 0, 1);
    end
    tick();
    check_all("pz_done", 7, 0, 1, 2);
    abort();

    // STOP at NUM=6 with TC=10, then STOP+START together
    launch(4'd10, 1'b0);
    for (int k = 1; k <= 6; k++) tick();
    check("stop.num6", 32'(NUM), 6);
    abort();
    tick();
    check_all("stop_idle", 0, 0, 0, 0);
    STOP  = 1'b1;
    START = 1'b1;
    tick();
    STOP  = 1'b0;
    START = 1'b0;
    check_all("stop_start", 0, 0, 0, 0);

    // One-shot TC=0
    launch(4'd0, 1'b0);
    tick();
    check_all("tc0_done", 0, 0, 1, 2);
    tick();
    check_all("tc0_fin", 0, 0, 0, 2);
    abort();

    // Periodic TC=0: DONE every cycle
    launch(4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("ptc0", 0, 1, 1, 1);
    end
    abort();

    // Periodic TC=15: full wrap, DONE every 16 cycles
    launch(4'd15, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("p15.num", 32'(NUM), 32'(k % 16));
      check("p15.done", 32'(DONE), 32'(k % 16 == 0));
    end
    abort();

    // RESET mid-run, including just before terminal
    launch(4'd3, 1'b0);
    for (int k = 1; k <= 3; k++) tick();
    check("rst_mid.num3", 32'(NUM), 3);
    RESET = 1'b1;
    tick();
    check_all("rst_mid", 0, 0, 0, 0);
    RESET = 1'b0;
    tick();
    check_all("rst_mid_after", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Synchronous controller that sequences a 4-bit up-counter through programmable count runs with start/stop/pause control, one-shot or periodic operation, and a terminal-count done pulse. It sits between software/control logic and the lab's 4-bit counter datapath, replacing free-running ripple counting with a fully synchronous, commandable count sequence.

## Interface
Parameters:
- WIDTH, 4, counter width; TC and NUM use this width.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  level-sampled command: begin a run (accepted in IDLE or FIN only).
- STOP  input  1  abort: return to IDLE, clear count.
- PAUSE  input  1  level: hold count while high in RUN.
- MODE  input  1  0 = one-shot, 1 = periodic; latched at START.
- TC  input  WIDTH  terminal count; latched at START.
- NUM  output  WIDTH  current count.
- BUSY  output  1  high while state is RUN.
- DONE  output  1  registered one-cycle pulse at terminal count.
- STATE  output  2  current FSM state encoding (debug).

## Operation
- States: IDLE (2'b00), RUN (2'b01), FIN (2'b10); 2'b11 unused, decodes to IDLE on next edge.
- Command priority per edge: RESET > STOP > START > PAUSE > count.
- IDLE: NUM = 0. START=1 -> RUN; tc_q <= TC, mode_q <= MODE; NUM stays 0.
- RUN, PAUSE=1: NUM, tc_q, state held; no terminal action, DONE = 0.
- RUN, PAUSE=0, NUM != tc_q: NUM <= NUM + 1 (modulo 2^WIDTH).
- RUN, PAUSE=0, NUM == tc_q: DONE <= 1 for one cycle; one-shot -> FIN, NUM held at tc_q; periodic -> NUM <= 0, stay RUN.
- FIN: NUM holds tc_q, BUSY = 0. START -> RUN with fresh latch of TC/MODE, NUM <= 0. STOP -> IDLE, NUM <= 0.
- START while in RUN: ignored; TC/MODE changes during RUN have no effect.
- STOP in any state: IDLE, NUM <= 0, DONE <= 0 the following cycle.
- TC = 0: one-shot finishes one edge after start; periodic yields NUM = 0 constantly with DONE high every cycle.
- TC = 2^WIDTH-1 periodic: natural wrap 15 -> 0 coincides with terminal reload.

## Timing
- Reset values: state IDLE, NUM = 0, BUSY = 0, DONE = 0, tc_q = 0, mode_q = 0.
- All outputs registered; no combinational input-to-output paths.
- START accepted at edge E0: state RUN, NUM = 0 after E0; NUM = k after edge Ek.
- DONE high during the cycle after edge E(TC+1) (unpaused); each cycle with PAUSE high in RUN delays this by one cycle.
- Periodic period = TC+1 cycles per DONE pulse, unpaused.
- RESET or STOP mid-run takes effect at the same edge; no DONE is produced by an aborted run.

## Structure
- Shared package counter_pkg: WIDTH default constant, state encoding localparams/typedef (IDLE, RUN, FIN), MODE encodings (ONESHOT, PERIODIC).
- One sub-module natural: sync_counter4 (CLK, clear, enable, NUM) — synchronous clearable enabled counter; counter_sequencer holds FSM, tc_q/mode_q latches, terminal compare, and DONE register.

## Test plan
- Reset with START held high -> NUM = 0, BUSY = 0, DONE = 0, STATE = IDLE until RESET deasserts.
- One-shot TC = 5: START one cycle -> NUM 0,1,2,3,4,5, DONE single pulse, STATE = FIN, NUM holds 5; second START restarts from 0.
- Periodic TC = 3, 12 cycles -> NUM 0,1,2,3,0,1,2,3,...; DONE pulses every 4 cycles; TC changed to 9 mid-run has no effect.
- One-shot TC = 7 with PAUSE high 3 cycles at NUM = 4 -> NUM holds 4 for 3 cycles, DONE delayed by exactly 3 cycles.
- STOP asserted at NUM = 6 (TC = 10) -> next edge NUM = 0, STATE = IDLE, no DONE; STOP and START same cycle -> IDLE.
- Edge cases: one-shot TC = 0 -> DONE one cycle after start, NUM = 0; periodic TC = 15 -> 0..15 wrap, DONE every 16 cycles; RESET mid-run -> all outputs to reset values next edge.
